// File: rtl/lsu_stage.sv
`default_nettype none
// ============================================================================
// Module   : lsu_stage
// Purpose  : Load/store stage between EXU and WBU; one data-memory req/resp
//            transaction per load/store, lane alignment and sign extension.
// Options  : define LSU_MISALIGN_TRAP_EN to fault misaligned half/word access
// Revision : 1.0 - initial release
// ============================================================================
module lsu_stage #(
    parameter int RESP_TIMEOUT = 256,
    parameter int CNT_W        = 9
) (
    input  logic        i_clock,
    input  logic        i_rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_result,
    input  logic [31:0] i_store_data,
    input  logic        i_mem_ren,
    input  logic        i_mem_wen,
    input  logic [3:0]  i_mem_wmask,
    input  logic [2:0]  i_mem_read_t,
    input  logic [4:0]  i_rd,
    input  logic        i_reg_wen,
    output logic        o_mem_req,
    input  logic        i_mem_gnt,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_we,
    output logic [3:0]  o_mem_wstrb,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_rerr,
    output logic        o_valid,
    input  logic        i_wb_ready,
    output logic [31:0] o_wb_data,
    output logic [4:0]  o_rd,
    output logic        o_reg_wen,
    output logic        o_err
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_RESP = 2'd2,
        DONE      = 2'd3
    } state_t;

    localparam bit             WDOG_EN  = (RESP_TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = WDOG_EN ? CNT_W'(RESP_TIMEOUT - 1) : '0;

    state_t            state;
    state_t            state_next;

    logic [1:0]        addr_lo;
    logic              is_store;
    logic [2:0]        read_t;
    logic [4:0]        rd_q;
    logic              reg_wen_q;
    logic              err_q;
    logic [31:0]       wb_data_q;
    logic [31:0]       mem_addr_q;
    logic              we_q;
    logic [3:0]        wstrb_q;
    logic [31:0]       wdata_q;
    logic [CNT_W-1:0]  cnt;

    logic              mem_op_in;
    logic              store_in;
    logic              misaligned_in;
    logic              timeout;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic [31:0]       load_ext;

    // A set write enable wins over read enable.
    assign mem_op_in = i_mem_ren | i_mem_wen;
    assign store_in  = i_mem_wen;

`ifdef LSU_MISALIGN_TRAP_EN
    logic half_in;
    logic word_in;
    assign half_in = store_in ? (i_mem_wmask == 4'b0011) : (i_mem_read_t[1:0] == 2'b01);
    assign word_in = store_in ? (i_mem_wmask == 4'b1111) : (i_mem_read_t[1:0] == 2'b10);
    assign misaligned_in = mem_op_in &
                           ((half_in & i_result[0]) | (word_in & (i_result[1:0] != 2'b00)));
`else
    assign misaligned_in = 1'b0;
`endif

    assign timeout = WDOG_EN && (cnt == CNT_LAST);

    always_comb begin
        lane_b = i_mem_rdata[7:0];
        case (addr_lo)
            2'd1:    lane_b = i_mem_rdata[15:8];
            2'd2:    lane_b = i_mem_rdata[23:16];
            2'd3:    lane_b = i_mem_rdata[31:24];
            default: lane_b = i_mem_rdata[7:0];
        endcase
    end

    assign lane_h = addr_lo[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];

    always_comb begin
        load_ext = i_mem_rdata;
        case (read_t)
            3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
            3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
            3'b100:  load_ext = {24'd0, lane_b};
            3'b101:  load_ext = {16'd0, lane_h};
            default: load_ext = i_mem_rdata;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (i_valid) begin
                    state_next = (mem_op_in && !misaligned_in) ? REQ : DONE;
                end
            end
            REQ: begin
                if (i_mem_gnt) begin
                    state_next = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (i_mem_rvalid || timeout) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (i_wb_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            addr_lo    <= 2'b00;
            is_store   <= 1'b0;
            read_t     <= 3'b000;
            rd_q       <= 5'd0;
            reg_wen_q  <= 1'b0;
            err_q      <= 1'b0;
            wb_data_q  <= 32'd0;
            mem_addr_q <= 32'd0;
            we_q       <= 1'b0;
            wstrb_q    <= 4'd0;
            wdata_q    <= 32'd0;
            cnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        addr_lo    <= i_result[1:0];
                        is_store   <= store_in;
                        read_t     <= i_mem_read_t;
                        rd_q       <= i_rd;
                        reg_wen_q  <= i_reg_wen;
                        err_q      <= misaligned_in;
                        wb_data_q  <= mem_op_in ? 32'd0 : i_result;
                        mem_addr_q <= {i_result[31:2], 2'b00};
                        we_q       <= store_in;
                        wstrb_q    <= store_in ? 4'(i_mem_wmask << i_result[1:0]) : 4'd0;
                        wdata_q    <= store_in ? (i_store_data << {i_result[1:0], 3'b000}) : 32'd0;
                    end
                end
                REQ: begin
                    if (i_mem_gnt) begin
                        cnt <= '0;
                    end
                end
                WAIT_RESP: begin
                    cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (i_mem_rvalid) begin
                        err_q     <= i_mem_rerr;
                        wb_data_q <= is_store ? 32'd0 : load_ext;
                    end else if (timeout) begin
                        err_q     <= 1'b1;
                        wb_data_q <= 32'd0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_ready     = (state == IDLE);
    assign o_mem_req   = (state == REQ);
    assign o_valid     = (state == DONE);
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_we    = we_q;
    assign o_mem_wstrb = wstrb_q;
    assign o_mem_wdata = wdata_q;
    assign o_wb_data   = wb_data_q;
    assign o_rd        = rd_q;
    assign o_err       = err_q;
    assign o_reg_wen   = reg_wen_q & ~err_q & ~is_store;

endmodule
`default_nettype wire

// File: doc/lsu_stage.md
Name: lsu_stage

Overview:
- Load/store stage directly downstream of the execute unit.
- Accepts one executed instruction at a time over a valid/ready handshake.
- For loads and stores, issues a single request/response transaction on the data-memory port and aligns/extends data. Non-memory instructions pass straight through.
- Presents the write-back payload to the WBU over a second valid/ready handshake.

Parameters:
- RESP_TIMEOUT, 256: cycles allowed in WAIT_RESP before the access is abandoned with error; 0 disables the watchdog.
- CNT_W, 9: width of the watchdog counter; must hold RESP_TIMEOUT.

Ports:
- i_clock  in  1  clock; all state updates on the rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  EXU payload valid
- o_ready  out  1  stage can accept a payload (IDLE only)
- i_result  in  32  EXU result: ALU value, or effective address for loads/stores
- i_store_data  in  32  rs2 value for stores
- i_mem_ren  in  1  instruction is a load
- i_mem_wen  in  1  instruction is a store
- i_mem_wmask  in  4  store mask: 0001 byte, 0011 half, 1111 word
- i_mem_read_t  in  3  load funct3: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu
- i_rd  in  5  destination register index
- i_reg_wen  in  1  register write enable
- o_mem_req  out  1  memory request valid
- i_mem_gnt  in  1  memory accepts the request this cycle
- o_mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- o_mem_we  out  1  1 = write
- o_mem_wstrb  out  4  byte strobes, shifted to byte lane
- o_mem_wdata  out  32  store data, shifted to byte lane
- i_mem_rvalid  in  1  response valid (one pulse per request)
- i_mem_rdata  in  32  read data word
- i_mem_rerr  in  1  response error, qualified by i_mem_rvalid
- o_valid  out  1  write-back payload valid
- i_wb_ready  in  1  WBU accepts the payload
- o_wb_data  out  32  value to write to rd
- o_rd  out  5  destination index
- o_reg_wen  out  1  write enable; forced 0 on error
- o_err  out  1  access fault (bus error, timeout, misalign)

Behaviour:
- Reset (asynchronous, i_rst_n=0): state IDLE; o_valid=0, o_mem_req=0, o_mem_we=0, o_mem_wstrb=0, o_err=0, o_reg_wen=0, o_wb_data=0, o_rd=0, o_mem_addr=0, o_mem_wdata=0; watchdog counter=0. Reset mid-transaction abandons it; a later i_mem_rvalid is ignored in IDLE.
- States: IDLE, REQ, WAIT_RESP, DONE.
- IDLE:
  - o_ready=1.
  - On i_valid, capture all inputs.
  - If i_mem_ren or i_mem_wen: go to REQ. Otherwise load o_wb_data=i_result and go to DONE.
  - Fall-through latency is 1 cycle.
- REQ:
  - o_mem_req=1; address, strobes and data held stable until i_mem_gnt.
  - i_mem_gnt: go to WAIT_RESP and clear the counter.
  - Waits for grant indefinitely.
- WAIT_RESP:
  - Counter increments each cycle.
  - i_mem_rvalid (including in the cycle right after grant): go to DONE. o_err=i_mem_rerr.
  - For loads, o_wb_data = extended lane. Byte lane = addr[1:0]; half lane = addr[1]. lb/lh sign-extend; lbu/lhu zero-extend; lw takes the full word.
  - For stores, o_wb_data=0 and o_reg_wen=0.
  - Timeout: counter reaches RESP_TIMEOUT-1 with no rvalid (RESP_TIMEOUT≠0) → DONE with o_err=1.
- DONE:
  - o_valid=1; outputs held until i_wb_ready.
  - On accept, go to IDLE. No back-to-back overlap: at most one instruction in flight, throughput ≤1 per 2 cycles.
- Store lane shift: o_mem_wstrb = i_mem_wmask << addr[1:0]; o_mem_wdata = i_store_data << (8*addr[1:0]). The result is truncated to 4/32 bits.
- If both i_mem_ren and i_mem_wen are set, treat as a store.
- o_reg_wen = captured i_reg_wen AND NOT o_err AND NOT store.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined: an access is misaligned when it is a half with addr[0]=1, or a word with addr[1:0]≠0. A misaligned access skips REQ/WAIT_RESP and goes IDLE→DONE in 1 cycle with o_err=1, o_reg_wen=0, and no o_mem_req.
- Undefined: no check. The access is issued with the truncated shifted strobe/data; loads use the lane selected by addr.

Test Plan:
- Non-memory op: i_result=0x1234_5678, rd=5, reg_wen=1 → o_valid next cycle with o_wb_data=0x12345678, o_rd=5, no o_mem_req.
- lb at 0x8000_0003, rdata=0x80FF_FF7F → o_mem_addr=0x80000000; o_wb_data=0xFFFF_FF80. Same access as lbu → 0x0000_0080.
- sh at 0x8000_0002, data 0xAAAA_BEEF → o_mem_wstrb=1100, o_mem_wdata=0xBEEF_0000, o_mem_we=1, o_reg_wen=0 at DONE.
- Grant delayed 3 cycles, rvalid 2 cycles after grant, i_wb_ready low 2 cycles → request and outputs stable throughout; o_ready=0 until the accept cycle.
- Response with i_mem_rerr=1 → o_err=1, o_reg_wen=0. With RESP_TIMEOUT=4 and no rvalid → o_err=1 exactly 4 cycles after grant.
- With LSU_MISALIGN_TRAP_EN: lw at 0x8000_0001 → o_err=1 one cycle later, o_mem_req never asserted. Without the macro: the request is issued.
